// File: rtl/ram_pkg.sv
// ============================================================================
// ram_pkg: shared access-mode encodings, FSM state and response-stage types.
// Rev 1.0
// ============================================================================
`default_nettype none

package ram_pkg;

  localparam logic [2:0] MODE_WORD = 3'b100;
  localparam logic [2:0] MODE_HALF = 3'b010;
  localparam logic [2:0] MODE_BYTE = 3'b001;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] rdata;
  } rsp_stage_t;

  localparam rsp_stage_t RSP_IDLE = '{valid: 1'b0, err: 1'b0, rdata: 32'h0};

endpackage

`default_nettype wire

// File: rtl/ram_load_ext.sv
// ============================================================================
// ram_load_ext: selects the addressed byte/half of a word and sign/zero-extends.
// Rev 1.0
// ============================================================================
`default_nettype none

module ram_load_ext
  import ram_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  lane_i,
  input  logic [2:0]  mode_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = word_i[7:0];
    case (lane_i)
      2'd0:    w_byte = word_i[7:0];
      2'd1:    w_byte = word_i[15:8];
      2'd2:    w_byte = word_i[23:16];
      default: w_byte = word_i[31:24];
    endcase
  end

  // Halves always start on an even lane; the low lane bit never moves them.
  assign w_half = lane_i[1] ? word_i[31:16] : word_i[15:0];

  always_comb begin
    data_o = word_i;
    case (mode_i)
      MODE_BYTE: data_o = {{24{w_byte[7] & ~unsigned_i}}, w_byte};
      MODE_HALF: data_o = {{16{w_half[15] & ~unsigned_i}}, w_half};
      default:   data_o = word_i;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/sized_data_ram.sv
// ============================================================================
// sized_data_ram: byte-addressed LE data RAM, valid/ready port, RD_LAT response
// pipe, init sweep after reset. Rev 1.0. Option: SIZED_DATA_RAM_MISALIGN_CHK_EN.
// ============================================================================
`default_nettype none

module sized_data_ram
  import ram_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int RD_LAT      = 1,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_mode,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(DEPTH_WORDS - 1);

  if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_rd_lat
    $error("sized_data_ram: RD_LAT must be 1 or 2");
  end
  if (DEPTH_WORDS < 4 || (1 << IDX_W) != DEPTH_WORDS) begin : g_bad_depth
    $error("sized_data_ram: DEPTH_WORDS must be a power of two >= 4");
  end
  if (ADDR_W < IDX_W + 2) begin : g_bad_addr_w
    $error("sized_data_ram: ADDR_W too narrow for DEPTH_WORDS");
  end

  state_t           state_q, state_d;
  logic [IDX_W-1:0] clr_cnt_q, clr_cnt_d;
  logic             w_clr_we;

  logic [31:0]      mem_q [DEPTH_WORDS];

  logic             w_accept;
  logic [IDX_W-1:0] w_idx;
  logic [1:0]       w_lane;
  logic             w_mode_err;
  logic             w_range_err;
  logic             w_misalign_err;
  logic             w_err;
  logic             w_store;
  logic [3:0]       w_be;
  logic [31:0]      w_wdata;
  logic [31:0]      w_rd_word;
  logic [31:0]      w_ext;
  rsp_stage_t       stage_d;
  rsp_stage_t       pipe_q [RD_LAT];

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == C_LAST_IDX) begin
          state_d = READY;
        end
      end
      READY:   state_d = READY;
      default: state_d = CLEAR;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    w_clr_we  = 1'b0;
    case (state_q)
      CLEAR:   w_clr_we  = 1'b1;
      READY:   req_ready = 1'b1;
      default: w_clr_we  = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------- decode
  assign w_accept   = req_valid && req_ready;
  assign w_idx      = req_addr[IDX_W+1:2];
  assign w_lane     = req_addr[1:0];
  assign w_mode_err = !$onehot(req_mode);

  if (ADDR_W > IDX_W + 2) begin : g_range
    assign w_range_err = |req_addr[ADDR_W-1:IDX_W+2];
  end else begin : g_no_range
    assign w_range_err = 1'b0;
  end

`ifdef SIZED_DATA_RAM_MISALIGN_CHK_EN
  assign w_misalign_err = ((req_mode == MODE_HALF) && req_addr[0]) ||
                          ((req_mode == MODE_WORD) && (req_addr[1:0] != 2'b00));
`else
  assign w_misalign_err = 1'b0;
`endif

  assign w_err   = w_mode_err || w_range_err || w_misalign_err;
  assign w_store = w_accept && req_we && !w_err;

  // Store data is replicated across lanes so each byte enable picks its slice.
  always_comb begin
    w_be    = 4'b0000;
    w_wdata = req_wdata;
    case (req_mode)
      MODE_BYTE: begin
        w_be    = 4'b0001 << w_lane;
        w_wdata = {4{req_wdata[7:0]}};
      end
      MODE_HALF: begin
        w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{req_wdata[15:0]}};
      end
      MODE_WORD: w_be = 4'b1111;
      default:   w_be = 4'b0000;
    endcase
  end

  // ---------------------------------------------------------------- array
  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      mem_q[clr_cnt_q] <= '0;
    end else if (w_store) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) begin
          mem_q[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
        end
      end
    end
  end

  assign w_rd_word = mem_q[w_idx];

  ram_load_ext u_load_ext (
    .word_i     (w_rd_word),
    .lane_i     (w_lane),
    .mode_i     (req_mode),
    .unsigned_i (req_unsigned),
    .data_o     (w_ext)
  );

  // ---------------------------------------------------------------- response
  always_comb begin
    stage_d       = RSP_IDLE;
    stage_d.valid = w_accept;
    stage_d.err   = w_accept && w_err;
    if (w_accept && !req_we && !w_err) begin
      stage_d.rdata = w_ext;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_q[i] <= RSP_IDLE;
      end
    end else begin
      pipe_q[0] <= stage_d;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign rsp_valid = pipe_q[RD_LAT-1].valid;
  assign rsp_err   = pipe_q[RD_LAT-1].valid && pipe_q[RD_LAT-1].err;
  assign rsp_rdata = pipe_q[RD_LAT-1].valid ? pipe_q[RD_LAT-1].rdata : 32'h0;

endmodule

`default_nettype wire

// File: tb/tb_sized_data_ram.sv
// ============================================================================
// tb_sized_data_ram: directed + random requests against a byte-array model.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_sized_data_ram;
  import ram_pkg::*;

  localparam int DEPTH = 16;
  localparam int LAT   = 2;
  localparam int AW    = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [2:0]    req_mode;
  logic          req_unsigned;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;

  always #5 clk = ~clk;

  sized_data_ram #(
    .DEPTH_WORDS (DEPTH),
    .RD_LAT      (LAT),
    .ADDR_W      (AW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_mode     (req_mode),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err)
  );

  typedef struct {
    int          due;
    logic        err;
    logic [31:0] rdata;
    logic        has_k;
    logic        kerr;
    logic [31:0] k;
    string       tag;
  } exp_t;

  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  exp_t        expq[$];
  logic [7:0]  ref_mem [4*DEPTH];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: bytes in a flat array; loads built arithmetically from them.
  task automatic model_accept(input logic we, input logic [2:0] mode, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic has_k, input logic kerr, input logic [31:0] k,
                              input string tag);
    logic err;
    int   a, v;
    exp_t e;
    err = !(mode == 3'b001 || mode == 3'b010 || mode == 3'b100) || (addr >= 32'(4*DEPTH));
`ifdef SIZED_DATA_RAM_MISALIGN_CHK_EN
    if (mode == 3'b010 && addr[0]) err = 1'b1;
    if (mode == 3'b100 && addr[1:0] != 2'b00) err = 1'b1;
`endif
    v = 0;
    if (!err) begin
      a = int'(addr);
      if (mode == 3'b010) a = a - (a % 2);
      if (mode == 3'b100) a = a - (a % 4);
      if (we) begin
        ref_mem[a] = wdata[7:0];
        if (mode != 3'b001) ref_mem[a+1] = wdata[15:8];
        if (mode == 3'b100) begin
          ref_mem[a+2] = wdata[23:16];
          ref_mem[a+3] = wdata[31:24];
        end
      end else if (mode == 3'b001) begin
        v = int'(ref_mem[a]);
        if (!uns && v >= 128) v = v - 256;
      end else if (mode == 3'b010) begin
        v = int'(ref_mem[a]) + 256 * int'(ref_mem[a+1]);
        if (!uns && v >= 32768) v = v - 65536;
      end else begin
        v = int'(ref_mem[a]) + 256 * int'(ref_mem[a+1]) +
            65536 * int'(ref_mem[a+2]) + 16777216 * int'(ref_mem[a+3]);
      end
    end
    e.due   = cyc + LAT - 1;
    e.err   = err;
    e.rdata = 32'(v);
    e.has_k = has_k;
    e.kerr  = kerr;
    e.k     = k;
    e.tag   = tag;
    expq.push_back(e);
  endtask

  task automatic check_rsp();
    exp_t e;
    if (expq.size() > 0 && expq[0].due == cyc) begin
      e = expq.pop_front();
      check({"rsp_", e.tag}, 64'({rsp_valid, rsp_err, rsp_rdata}), 64'({1'b1, e.err, e.rdata}));
      if (e.has_k) begin
        check({"const_", e.tag}, 64'({rsp_err, rsp_rdata}), 64'({e.kerr, e.k}));
      end
    end else begin
      check("idle_rsp", 64'({rsp_valid, rsp_err, rsp_rdata}), 64'(0));
    end
  endtask

  task automatic step(input logic v, input logic we, input logic [2:0] mode, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic has_k, input logic kerr, input logic [31:0] k, input string tag);
    logic acc;
    req_valid    = v;
    req_we       = we;
    req_mode     = mode;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    acc          = v && req_ready;
    @(posedge clk);
    cyc++;
    if (v) check({"accept_", tag}, 64'(acc), 64'(1'b1));
    if (acc) model_accept(we, mode, uns, addr, wdata, has_k, kerr, k, tag);
    #1;
    check_rsp();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'b100, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, "idle");
  endtask

  task automatic ld(input logic [2:0] mode, input logic uns, input logic [31:0] addr,
                    input logic kerr, input logic [31:0] k, input string tag);
    step(1'b1, 1'b0, mode, uns, addr, 32'h0, 1'b1, kerr, k, tag);
  endtask

  task automatic st(input logic [2:0] mode, input logic [31:0] addr, input logic [31:0] wdata,
                    input logic kerr, input string tag);
    step(1'b1, 1'b1, mode, 1'b0, addr, wdata, 1'b1, kerr, 32'h0, tag);
  endtask

  task automatic hold_reset(input int n);
    rst_n     = 1'b0;
    req_valid = 1'b0;
    expq.delete();
    foreach (ref_mem[i]) ref_mem[i] = 8'h00;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      cyc++;
      #1;
      check("reset_outputs", 64'({req_ready, rsp_valid, rsp_err, rsp_rdata}), 64'(0));
    end
  endtask

  task automatic release_count(input int limit, output int n);
    @(negedge clk);
    rst_n = 1'b1;
    n     = 0;
    while (n < limit) begin
      @(posedge clk);
      cyc++;
      n++;
      #1;
      check_rsp();
      if (req_ready) break;
    end
  endtask

  initial begin
    int          n;
    logic        r_v, r_we, r_uns;
    logic [2:0]  r_mode;
    logic [31:0] r_addr;
    int          sel;

    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_mode     = 3'b100;
    req_unsigned = 1'b0;
    req_addr     = '0;
    req_wdata    = '0;

    hold_reset(3);
    release_count(4*DEPTH, n);
    check("ready_latency", 64'(n), 64'(DEPTH));

    ld(MODE_WORD, 1'b0, 32'h10, 1'b0, 32'h0000_0000, "ld_w_10_cleared");
    st(MODE_WORD, 32'h0, 32'h8765_4321, 1'b0, "st_w_0");
    ld(MODE_BYTE, 1'b0, 32'h1, 1'b0, 32'h0000_0043, "ld_b_1_s");
    ld(MODE_HALF, 1'b1, 32'h2, 1'b0, 32'h0000_8765, "ld_h_2_u");
    ld(MODE_HALF, 1'b0, 32'h2, 1'b0, 32'hFFFF_8765, "ld_h_2_s");
    ld(MODE_WORD, 1'b0, 32'h0, 1'b0, 32'h8765_4321, "ld_w_0_a");
    st(MODE_BYTE, 32'h3, 32'h0000_00FE, 1'b0, "st_b_3");
    ld(MODE_BYTE, 1'b0, 32'h3, 1'b0, 32'hFFFF_FFFE, "ld_b_3_s");
    ld(MODE_BYTE, 1'b1, 32'h3, 1'b0, 32'h0000_00FE, "ld_b_3_u");
    ld(MODE_WORD, 1'b0, 32'h0, 1'b0, 32'hFE65_4321, "ld_w_0_b");
    st(MODE_HALF, 32'h2, 32'h0000_6587, 1'b0, "st_h_2");
    ld(MODE_WORD, 1'b0, 32'h0, 1'b0, 32'h6587_4321, "ld_w_0_c");
`ifdef SIZED_DATA_RAM_MISALIGN_CHK_EN
    st(MODE_HALF, 32'h1, 32'h0000_1234, 1'b1, "st_h_1_misaligned");
    ld(MODE_WORD, 1'b0, 32'h0, 1'b0, 32'h6587_4321, "ld_w_0_unchanged");
    ld(MODE_WORD, 1'b0, 32'h2, 1'b1, 32'h0, "ld_w_2_misaligned");
`else
    st(MODE_HALF, 32'h1, 32'h0000_1234, 1'b0, "st_h_1_lane0");
    ld(MODE_WORD, 1'b0, 32'h0, 1'b0, 32'h6587_1234, "ld_w_0_lane0");
    ld(MODE_WORD, 1'b0, 32'h2, 1'b0, 32'h6587_1234, "ld_w_2_ignored");
`endif
    st(MODE_WORD, 32'(4*DEPTH), 32'hDEAD_BEEF, 1'b1, "st_range");
    ld(MODE_BYTE, 1'b1, 32'(4*DEPTH-1), 1'b0, 32'h0, "ld_b_last");
    ld(3'b011, 1'b0, 32'h0, 1'b1, 32'h0, "ld_mode_011");
    ld(3'b000, 1'b0, 32'h0, 1'b1, 32'h0, "ld_mode_000");
    st(3'b110, 32'h8, 32'h1111_1111, 1'b1, "st_mode_110");
    ld(MODE_WORD, 1'b0, 32'h8, 1'b0, 32'h0, "ld_w_8_untouched");
    idle(LAT + 1);

    // Reset in the middle of the init sweep restarts it from word 0.
    hold_reset(2);
    release_count(DEPTH/2, n);
    check("midclear_not_ready", 64'(req_ready), 64'(1'b0));
    hold_reset(2);
    release_count(4*DEPTH, n);
    check("ready_latency_restart", 64'(n), 64'(DEPTH));

    // Reset with loads in flight: their responses must never appear.
    st(MODE_WORD, 32'h8, 32'hA5A5_A5A5, 1'b0, "st_w_8");
    ld(MODE_WORD, 1'b0, 32'h8, 1'b0, 32'hA5A5_A5A5, "ld_w_8_inflight0");
    req_valid    = 1'b1;
    req_we       = 1'b0;
    req_mode     = MODE_WORD;
    req_addr     = 32'h8;
    @(posedge clk);
    cyc++;
    rst_n = 1'b0;
    hold_reset(3);
    release_count(4*DEPTH, n);
    check("ready_latency_inflight", 64'(n), 64'(DEPTH));
    ld(MODE_WORD, 1'b0, 32'h8, 1'b0, 32'h0, "ld_w_8_swept");
    idle(LAT + 1);

    for (int i = 0; i < 400; i++) begin
      r_v   = ($urandom_range(0, 9) != 0);
      r_we  = $urandom_range(0, 1) == 1;
      r_uns = $urandom_range(0, 1) == 1;
      sel   = int'($urandom_range(0, 9));
      if (sel < 3)      r_mode = MODE_BYTE;
      else if (sel < 6) r_mode = MODE_HALF;
      else if (sel < 9) r_mode = MODE_WORD;
      else              r_mode = 3'($urandom_range(0, 7));
      sel = int'($urandom_range(0, 19));
      if (sel == 0)      r_addr = $urandom;
      else if (sel == 1) r_addr = 32'(4*DEPTH);
      else               r_addr = 32'($urandom_range(0, 4*DEPTH-1));
      step(r_v, r_we, r_mode, r_uns, r_addr, $urandom, 1'b0, 1'b0, 32'h0, "rand");
    end
    idle(LAT + 2);
    check("queue_drained", 64'(expq.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
